// File: rtl/game_pkg.sv
// Shared constants and types for the game display pipeline.
package game_pkg;

  localparam int BCD_DIGITS_INT = 5;
  localparam int BCD_DISP_MAX   = 999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added
// before the shift, so that it carries correctly into the next digit.
module bcd_add3_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/signed_bcd_converter.sv
// Iterative two's-complement to sign-magnitude BCD converter (double dabble),
// saturating the displayed value at 999.
//   state | meaning
//   IDLE  | waiting for a request, o_ready high
//   SHIFT | one add-3/shift step per cycle, W cycles in total
//   DONE  | result registers just loaded, o_valid high
module signed_bcd_converter
  import game_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_value,
  output logic         o_ready,
  output logic         o_valid,
  output logic         o_neg,
  output logic [3:0]   o_hundreds,
  output logic [3:0]   o_tens,
  output logic [3:0]   o_ones,
  output logic         o_ovf
);

  localparam int CW = $clog2(W);
  localparam int BW = 4 * BCD_DIGITS_INT;

  bcd_state_t     state_q, state_d;
  logic [W-1:0]   mag_q;
  logic           neg_q;
  logic [BW-1:0]  bcd_q, bcd_adj, bcd_shift;
  logic [CW-1:0]  cnt_q;
  logic           accept, last_shift;

  for (genvar g = 0; g < BCD_DIGITS_INT; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .d(bcd_q[4*g +: 4]),
      .q(bcd_adj[4*g +: 4])
    );
  end

  assign bcd_shift  = {bcd_adj[BW-2:0], mag_q[W-1]};
  assign o_ready    = (state_q == IDLE);
  assign accept     = i_valid & o_ready;
  assign last_shift = (state_q == SHIFT) && (cnt_q == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mag_q      <= '0;
      neg_q      <= 1'b0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      o_valid    <= 1'b0;
      o_neg      <= 1'b0;
      o_hundreds <= '0;
      o_tens     <= '0;
      o_ones     <= '0;
      o_ovf      <= 1'b0;
    end else begin
      o_valid <= last_shift;
      if (accept) begin
        // The most negative input negates to 2^(W-1), which still fits unsigned.
        mag_q <= i_value[W-1] ? (~i_value + 1'b1) : i_value;
        neg_q <= i_value[W-1];
        bcd_q <= '0;
        cnt_q <= CW'(W - 1);
      end else if (state_q == SHIFT) begin
        bcd_q <= bcd_shift;
        mag_q <= {mag_q[W-2:0], 1'b0};
        cnt_q <= cnt_q - 1'b1;
      end
      // Outputs load from the final shift result so they are visible in DONE.
      if (last_shift) begin
        if (|bcd_shift[BW-1:12]) begin
          o_hundreds <= 4'd9;
          o_tens     <= 4'd9;
          o_ones     <= 4'd9;
          o_ovf      <= 1'b1;
        end else begin
          o_hundreds <= bcd_shift[11:8];
          o_tens     <= bcd_shift[7:4];
          o_ones     <= bcd_shift[3:0];
          o_ovf      <= 1'b0;
        end
        o_neg <= neg_q & (|bcd_shift);
      end
    end
  end

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Directed and random bench for signed_bcd_converter at W=12 and W=16,
// with expected results queued at each accept and checked on o_valid.
module tb_signed_bcd_converter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_valid, a_ready, a_ovalid, a_neg, a_ovf;
  logic [11:0] a_value;
  logic [3:0]  a_h, a_t, a_o;
  logic        b_valid, b_ready, b_ovalid, b_neg, b_ovf;
  logic [15:0] b_value;
  logic [3:0]  b_h, b_t, b_o;

  signed_bcd_converter #(.W(12)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .i_value(a_value),
    .o_ready(a_ready), .o_valid(a_ovalid), .o_neg(a_neg),
    .o_hundreds(a_h), .o_tens(a_t), .o_ones(a_o), .o_ovf(a_ovf)
  );

  signed_bcd_converter #(.W(16)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .i_value(b_value),
    .o_ready(b_ready), .o_valid(b_ovalid), .o_neg(b_neg),
    .o_hundreds(b_h), .o_tens(b_t), .o_ones(b_o), .o_ovf(b_ovf)
  );

  typedef struct {
    logic       neg;
    logic [3:0] h, t, o;
    logic       ovf;
    int         acc;
  } exp_t;

  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic exp_t model(input int v, input int acc);
    exp_t r;
    int   m;
    m     = (v < 0) ? -v : v;
    r.neg = (v < 0);
    r.acc = acc;
    if (m > game_pkg::BCD_DISP_MAX) begin
      r.h = 4'd9; r.t = 4'd9; r.o = 4'd9; r.ovf = 1'b1;
    end else begin
      r.h = 4'(m / 100); r.t = 4'((m / 10) % 10); r.o = 4'(m % 10); r.ovf = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard: every o_valid pulse must match the oldest queued request.
  always @(negedge clk) begin
    if (a_ovalid) begin
      check("a_expected_pending", 32'(qa.size() > 0), 1);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        check("a_neg", a_neg, ea.neg);
        check("a_hundreds", a_h, ea.h);
        check("a_tens", a_t, ea.t);
        check("a_ones", a_o, ea.o);
        check("a_ovf", a_ovf, ea.ovf);
        check("a_latency", cyc - ea.acc, 12);
        check("a_ready_in_done", a_ready, 0);
      end
    end
    if (b_ovalid) begin
      check("b_expected_pending", 32'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        check("b_neg", b_neg, eb.neg);
        check("b_hundreds", b_h, eb.h);
        check("b_tens", b_t, eb.t);
        check("b_ones", b_o, eb.o);
        check("b_ovf", b_ovf, eb.ovf);
        check("b_latency", cyc - eb.acc, 16);
      end
    end
  end

  task automatic convert(input bit wide, input int v);
    int n;
    n = 0;
    @(negedge clk);
    while (!(wide ? b_ready : a_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", wide ? b_ready : a_ready, 1);
    if (wide) begin
      b_valid = 1'b1; b_value = 16'(v); qb.push_back(model(v, cyc + 1));
    end else begin
      a_valid = 1'b1; a_value = 12'(v); qa.push_back(model(v, cyc + 1));
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wide ? b_ovalid : a_ovalid) && n < 60);
    check("done_wait", wide ? b_ovalid : a_ovalid, 1);
    @(negedge clk);
    check("ready_after_done", wide ? b_ready : a_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, n;
    int fixed16[4] = '{-32768, 32767, 999, -1000};
    rst = 1'b1;
    a_valid = 1'b0; a_value = '0;
    b_valid = 1'b0; b_value = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", a_ovalid, 0);
    check("rst_digits", {a_h, a_t, a_o}, 0);
    check("rst_neg_ovf", {a_neg, a_ovf}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", a_ready, 1);

    convert(0, 123);
    convert(0, -45);
    convert(0, 0);
    convert(0, -2048);

    // Abort a conversion in its fifth cycle; previous result had neg=1, ovf=1.
    @(negedge clk);
    a_valid = 1'b1; a_value = 12'd321;
    @(posedge clk);
    #1 a_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", a_ovalid, 0);
    check("abort_digits", {a_h, a_t, a_o}, 0);
    check("abort_neg_ovf", {a_neg, a_ovf}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", a_ready, 1);
    repeat (20) @(negedge clk);
    convert(0, 456);

    convert(0, 1000);
    convert(0, 999);

    // Held request whose value changes mid-conversion.
    @(negedge clk);
    c0 = cyc;
    a_valid = 1'b1; a_value = 12'd7; qa.push_back(model(7, cyc + 1));
    repeat (3) @(negedge clk);
    a_value = 12'd8;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_ready && n < 40);
    check("hold_second_accept_cycle", cyc - c0, 14);
    qa.push_back(model(8, cyc + 1));
    @(posedge clk);
    #1 a_valid = 1'b0;
    repeat (16) @(negedge clk);

    foreach (fixed16[i]) convert(1, fixed16[i]);
    for (int i = 0; i < 20; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      convert(1, int'($signed(r)));
    end

    repeat (5) @(negedge clk);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
